param_data_memory: RTL and testbench

Parametrised single-port data memory. Width, depth and read latency are configurable. Requests use a valid/ready handshake, and each request gets exactly one response pulse. After reset, an internal sweep state machine zero-fills the array, so the storage array has no reset; range-checked accesses flag errors. It sits between the datapath load/store stage and the memory-stage control.

---
 rtl/param_data_memory.sv | 133 +++++++++++++
 tb/tb_param_data_memory.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
`timescale 1ns/1ps
// Parametrised single-port data memory with a valid/ready request handshake,
// one response pulse per request and a post-reset zero-fill sweep.
module param_data_memory #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    parameter int INIT_ZERO  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LAT_W-1:0]  RD_LOAD   = LAT_W'(RD_LATENCY - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              pend_write;
    logic              pend_err;
    logic [DATA_W-1:0] rd_sample;

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
    assign req_idx   = req_addr[IDX_W-1:0];

    // The sweep and user writes share the single write port; they never overlap
    // because requests are only accepted once the sweep has finished.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        mem_wdata = req_wdata;
        if (state == ST_INIT) begin
            if (INIT_ZERO != 0) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt[IDX_W-1:0];
                mem_wdata = '0;
            end
        end else if (accept && req_write && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (accept && !req_write) begin
            rd_sample <= in_range ? mem[req_idx] : '0;
        end
    end

    // Control path: reset drops any pending response and restarts the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            lat_cnt    <= '0;
            pend_write <= 1'b0;
            pend_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_INIT: begin
                    if ((INIT_ZERO == 0) || (init_cnt == LAST_ADDR)) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        state      <= ST_BUSY;
                        pend_write <= req_write;
                        pend_err   <= !in_range;
                        lat_cnt    <= req_write ? '0 : RD_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (lat_cnt == '0) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pend_err;
                        if (!pend_write) begin
                            rsp_rdata <= rd_sample;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
`timescale 1ns/1ps
// Scoreboard bench: dut_a (DEPTH=200, RD_LATENCY=3, zero-fill) and
// dut_b (DEPTH=256, RD_LATENCY=1, no sweep) share request inputs; one is held in reset.
module tb_param_data_memory;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       req_valid, req_write;
    logic [7:0] req_addr, req_wdata;

    logic       ready_a, rsp_valid_a, rsp_err_a, init_done_a;
    logic [7:0] rsp_rdata_a;
    logic       ready_b, rsp_valid_b, rsp_err_b, init_done_b;
    logic [7:0] rsp_rdata_b;

    int         sel = 0;
    logic       ready, rsp_valid, rsp_err, init_done;
    logic [7:0] rsp_rdata;

    assign ready     = (sel != 0) ? ready_b     : ready_a;
    assign rsp_valid = (sel != 0) ? rsp_valid_b : rsp_valid_a;
    assign rsp_err   = (sel != 0) ? rsp_err_b   : rsp_err_a;
    assign init_done = (sel != 0) ? init_done_b : init_done_a;
    assign rsp_rdata = (sel != 0) ? rsp_rdata_b : rsp_rdata_a;

    always #5 clk = ~clk;

    param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(3), .INIT_ZERO(1)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .init_done(init_done_a)
    );

    param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .INIT_ZERO(0)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .init_done(init_done_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    logic [7:0] model [256];
    logic [7:0] last_rd;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation, in cycle too.
    always @(negedge clk) begin
        exp_t e;
        if (prev_valid) check_output("err_clear", {31'd0, rsp_err}, 0);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_rsp", {31'd0, rsp_valid}, 0);
            end else begin
                e = sb.pop_front();
                check_output("rsp_cycle", cycle, e.cyc);
                check_output("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check_output("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic push_expect(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input int lat, input int acc);
        exp_t e;
        int   depth;
        depth = (sel != 0) ? 256 : 200;
        e.cyc = acc + (wr ? 1 : lat);
        e.err = (int'(addr) >= depth);
        if (wr) begin
            e.rdata = last_rd;
            if (!e.err) model[addr] = wdata;
        end else begin
            e.rdata = e.err ? 8'h00 : model[addr];
            last_rd = e.rdata;
        end
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                  input int lat, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check_output("ready_timeout", {31'd0, ready}, 1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle + 1;
        push_expect(wr, addr, wdata, lat, acc);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_sweep(input int depth);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_output("sweep_len", n, depth);
        check_output("init_done", {31'd0, init_done}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"}, {31'd0, ready}, 0);
        check_output({tag, "_valid"}, {31'd0, rsp_valid}, 0);
        check_output({tag, "_rdata"}, {24'd0, rsp_rdata}, 0);
        check_output({tag, "_err"}, {31'd0, rsp_err}, 0);
        check_output({tag, "_done"}, {31'd0, init_done}, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, acc_prev;
        rst_a = 1'b0;
        rst_b = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        last_rd   = 8'h00;
        foreach (model[i]) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Sweep timing with a request held pending throughout
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd150;
        rst_a = 1'b1;
        wait_sweep(200);
        push_expect(1'b0, 8'd150, 8'h00, 3, cycle + 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Write then read with three-cycle read latency
        apply_stimulus(1'b1, 8'd100, 8'h83, 3, acc);
        drain();
        apply_stimulus(1'b0, 8'd100, 8'h00, 3, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("busy_ready", {31'd0, ready}, 0);
        end
        drain();

        // Out-of-range accesses flag errors and never alias
        apply_stimulus(1'b1, 8'd250, 8'h55, 3, acc);
        apply_stimulus(1'b0, 8'd250, 8'h00, 3, acc);
        apply_stimulus(1'b0, 8'd50, 8'h00, 3, acc);
        apply_stimulus(1'b0, 8'd199, 8'h00, 3, acc);
        apply_stimulus(1'b0, 8'd200, 8'h00, 3, acc);
        drain();

        // Reset two cycles after a read accept drops the response
        apply_stimulus(1'b0, 8'd100, 8'h00, 3, acc);
        drain();
        apply_stimulus(1'b0, 8'd100, 8'h00, 3, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst_a = 1'b0;
        sb.delete();
        last_rd = 8'h00;
        foreach (model[i]) model[i] = 8'h00;
        #1 check_reset_outputs("midreset");
        repeat (4) @(negedge clk);
        rst_a = 1'b1;
        wait_sweep(200);
        apply_stimulus(1'b0, 8'd100, 8'h00, 3, acc);
        drain();

        // Switch to the no-sweep instance
        rst_a = 1'b0;
        sel = 1;
        @(negedge clk);
        check_output("nz_done_pre", {31'd0, init_done}, 0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check_output("nz_done", {31'd0, init_done}, 1);
        check_output("nz_ready", {31'd0, ready}, 1);
        apply_stimulus(1'b1, 8'd0, 8'h7F, 1, acc);
        apply_stimulus(1'b0, 8'd0, 8'h00, 1, acc);
        drain();

        // Back-to-back requests accept once every two cycles
        apply_stimulus(1'b1, 8'd101, 8'h14, 1, acc_prev);
        apply_stimulus(1'b1, 8'd102, 8'hA0, 1, acc);
        check_output("b2b_gap", acc - acc_prev, 2);
        acc_prev = acc;
        apply_stimulus(1'b1, 8'd103, 8'h64, 1, acc);
        check_output("b2b_gap", acc - acc_prev, 2);
        for (int a = 101; a <= 103; a++) begin
            acc_prev = acc;
            apply_stimulus(1'b0, 8'(a), 8'h00, 1, acc);
            check_output("b2b_gap", acc - acc_prev, 2);
        end
        apply_stimulus(1'b1, 8'd102, 8'h3C, 1, acc);
        apply_stimulus(1'b0, 8'd102, 8'h00, 1, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
